instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the response-wait limit in cycles, legal range 2..255.
REQ-002 Parameter NOP_WORD, default 32'h00000013, SHALL set the reset and after-error value of ir.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 fetch_rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 pc_count  in  32  SHALL carry the current PC from the PC register.
REQ-006 pc_write  out  1  SHALL be the PC register load enable.
REQ-007 pc_seq  out  32  SHALL carry the sequential next PC, pc_count+4, for the PC source mux.
REQ-008 fetch_go  in  1  SHALL be the control unit's request for the next instruction.
REQ-009 fetch_busy  out  1  SHALL be high in states REQ and HOLD.
REQ-010 mem_req  out  1, mem_addr  out  32, mem_ack  in  1, mem_rdata  in  32  SHALL form the instruction-memory read port.
REQ-011 ir  out  32, ir_valid  out  1, ir_ready  in  1  SHALL form the instruction hand-off to decode.
REQ-012 misalign  out  1, timeout  out  1  SHALL be sticky error flags.

Function
REQ-013 The FSM SHALL have states IDLE, REQ, HOLD and ERR.
REQ-014 IDLE: fetch_go with pc_count[1:0]==0 SHALL latch pc_count into mem_addr and go to REQ next cycle; fetch_go with pc_count[1:0]!=0 SHALL go to ERR and set misalign.
REQ-015 REQ: mem_req SHALL be high; mem_addr SHALL be held stable; mem_ack SHALL capture mem_rdata into ir and go to HOLD.
REQ-016 pc_write SHALL be combinational, (state==REQ)&&mem_ack, so the PC advances on the same edge that loads ir; it SHALL never be high for more than one cycle per fetch.
REQ-017 HOLD: ir_valid SHALL be high and ir SHALL stay stable; ir_ready without fetch_go SHALL go to IDLE.
REQ-018 HOLD: ir_ready and fetch_go together SHALL go directly to REQ with mem_addr latched from the already-updated pc_count, with no IDLE cycle; misalignment SHALL be checked as in REQ-014.
REQ-019 mem_ack outside REQ and ir_ready outside HOLD SHALL be ignored.
REQ-020 fetch_go in REQ or HOLD SHALL be ignored except as described in REQ-018.
REQ-021 ERR SHALL hold mem_req, ir_valid and pc_write low, set ir to NOP_WORD, and be left only by reset.
REQ-022 pc_seq SHALL wrap modulo 2^32, so 32'hFFFFFFFC gives 32'h00000000.

Reset
REQ-023 fetch_rst SHALL immediately force state IDLE, mem_addr=0, ir=NOP_WORD, ir_valid=0, mem_req=0, misalign=0, timeout=0 and the wait counter to 0.
REQ-024 Reset asserted in REQ SHALL drop mem_req immediately; a mem_ack arriving during or after reset SHALL NOT load ir or pulse pc_write.

Configuration
REQ-025 With FETCH_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to REQ and increment each REQ cycle without mem_ack; reaching TIMEOUT_CYCLES SHALL go to ERR, set timeout and drop mem_req on the next cycle.
REQ-026 Without FETCH_TIMEOUT_EN: REQ SHALL wait indefinitely for mem_ack; timeout SHALL be tied 0 and no counter logic shall exist.

Verification
REQ-027 Reset, pc_count=0x100, fetch_go 1 cycle, mem_ack 2 cycles later with rdata 0x00500093 -> mem_addr 0x100, pc_write one pulse on the ack cycle, ir=0x00500093, ir_valid high until ir_ready.
REQ-028 HOLD with ir_ready=fetch_go=1, PC now 0x104 -> next cycle REQ with mem_addr 0x104, ir_valid low, no IDLE cycle.
REQ-029 pc_count=0x102, fetch_go -> ERR, misalign=1, mem_req never high, ir=0x00000013, ERR held through further fetch_go.
REQ-030 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, no mem_ack -> mem_req high exactly 4 cycles, then timeout=1 in ERR; without the macro mem_req stays high for 100 cycles.
REQ-031 fetch_rst pulsed mid-REQ, then mem_ack -> ir=0x00000013, pc_write never high, state IDLE.
REQ-032 pc_count=0xFFFFFFFC -> pc_seq=0x00000000.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: issues one memory read per fetch_go and hands the word to decode.
// Optional response timeout is compiled in with `define FETCH_TIMEOUT_EN.
`timescale 1ns/1ps

module instr_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_WORD       = 32'h00000013
) (
  input  logic        clk,
  input  logic        fetch_rst,
  input  logic [31:0] pc_count,
  output logic        pc_write,
  output logic [31:0] pc_seq,
  input  logic        fetch_go,
  output logic        fetch_busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic        misalign,
  output logic        timeout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  logic [1:0]  state_reg, state_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [31:0] ir_reg, ir_next;
  logic        misalign_reg, misalign_next;
  logic        start_fetch;
  logic        pc_aligned;
  logic        timeout_hit;

  // A new fetch starts from IDLE, or straight out of HOLD when decode consumes and asks again.
  assign start_fetch = fetch_go &&
                       ((state_reg == ST_IDLE) || ((state_reg == ST_HOLD) && ir_ready));
  assign pc_aligned  = (pc_count[1:0] == 2'b00);

  always_comb begin
    state_next    = state_reg;
    mem_addr_next = mem_addr_reg;
    ir_next       = ir_reg;
    misalign_next = misalign_reg;
    case (state_reg)
      ST_IDLE, ST_HOLD: begin
        if (start_fetch) begin
          if (pc_aligned) begin
            state_next    = ST_REQ;
            mem_addr_next = pc_count;
          end else begin
            state_next    = ST_ERR;
            misalign_next = 1'b1;
            ir_next       = NOP_WORD;
          end
        end else if ((state_reg == ST_HOLD) && ir_ready) begin
          state_next = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_next = ST_HOLD;
          ir_next    = mem_rdata;
        end else if (timeout_hit) begin
          state_next = ST_ERR;
          ir_next    = NOP_WORD;
        end
      end
      default: begin
        state_next = ST_ERR;
        ir_next    = NOP_WORD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge fetch_rst) begin
    if (fetch_rst) begin
      state_reg    <= ST_IDLE;
      mem_addr_reg <= 32'd0;
      ir_reg       <= NOP_WORD;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mem_addr_reg <= mem_addr_next;
      ir_reg       <= ir_next;
      misalign_reg <= misalign_next;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] wait_cnt_reg;
  logic [7:0] wait_cnt_inc;
  logic       timeout_reg;

  assign wait_cnt_inc = wait_cnt_reg + 8'd1;
  assign timeout_hit  = (state_reg == ST_REQ) && !mem_ack && (wait_cnt_inc == TIMEOUT_LIMIT);

  always_ff @(posedge clk or posedge fetch_rst) begin
    if (fetch_rst) begin
      wait_cnt_reg <= 8'd0;
      timeout_reg  <= 1'b0;
    end else begin
      if (start_fetch) begin
        wait_cnt_reg <= 8'd0;
      end else if ((state_reg == ST_REQ) && !mem_ack) begin
        wait_cnt_reg <= wait_cnt_inc;
      end
      if (timeout_hit) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign timeout = timeout_reg;
`else
  assign timeout_hit = 1'b0;
  assign timeout     = 1'b0;
`endif

  // pc_write is combinational so the PC register advances on the edge that captures ir.
  assign pc_write   = (state_reg == ST_REQ) && mem_ack;
  assign pc_seq     = pc_count + 32'd4;
  assign mem_req    = (state_reg == ST_REQ);
  assign ir_valid   = (state_reg == ST_HOLD);
  assign fetch_busy = (state_reg == ST_REQ) || (state_reg == ST_HOLD);
  assign mem_addr   = mem_addr_reg;
  assign ir         = ir_reg;
  assign misalign   = misalign_reg;

endmodule
